// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: result select, load alignment, retired-write history with two forwarding lookups.
// Optional retired-instruction counter is built only when WB_INSTRET_EN is defined.
module wb_retire_stage #(
    parameter int XLEN       = 32,
    parameter int HIST_DEPTH = 2,
    parameter int RA         = 5
) (
    input  logic            clk,
    input  logic            Rst,
    input  logic            dbg,
    input  logic            mem_hold,
    input  logic            mem_wb_valid,
    input  logic            mem_wb_regwrite,
    input  logic [RA-1:0]   mem_wb_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_wb_funct3,
    input  logic [2:0]      mem_wb_addr_lo,
    input  logic [XLEN-1:0] mem_wb_alures,
    input  logic [XLEN-1:0] mem_wb_memres,
    input  logic [XLEN-1:0] mem_wb_csr,
    input  logic [XLEN-1:0] mem_wb_pc4,
    output logic [XLEN-1:0] wb_res,
    output logic            wb_we,
    output logic [RA-1:0]   wb_rd,
    input  logic [RA-1:0]   q_rs1,
    input  logic [RA-1:0]   q_rs2,
    output logic            q_hit1,
    output logic            q_hit2,
    output logic [XLEN-1:0] q_data1,
    output logic [XLEN-1:0] q_data2,
    output logic [63:0]     instret
);

    // Keep the low `bits` of v, sign- or zero-extending to XLEN.
    function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v, input int unsigned bits,
                                            input logic sgn);
        logic [XLEN-1:0] sh;
        sh = v << (XLEN - bits);
        if (sgn) begin
            return $unsigned($signed(sh) >>> (XLEN - bits));
        end else begin
            return sh >> (XLEN - bits);
        end
    endfunction

    logic            adv_s;
    logic            we_noadv_s;
    logic [2:0]      off_s;
    logic [2:0]      h_off_s;
    logic [2:0]      w_off_s;
    logic [XLEN-1:0] load_s;

    logic            hist_vld_r [HIST_DEPTH];
    logic [RA-1:0]   hist_rd_r  [HIST_DEPTH];
    logic [XLEN-1:0] hist_res_r [HIST_DEPTH];

    assign adv_s      = !dbg && !mem_hold;
    assign we_noadv_s = mem_wb_valid && mem_wb_regwrite && (mem_wb_rd != {RA{1'b0}});
    assign wb_we      = we_noadv_s && adv_s && !Rst;
    assign wb_rd      = mem_wb_rd;

    // Offsets beyond the word are truncated; sub-size alignment bits are dropped, not trapped.
    assign off_s   = mem_wb_addr_lo & 3'((XLEN / 8) - 1);
    assign h_off_s = off_s & 3'b110;
    assign w_off_s = off_s & 3'b100;

    // Load data alignment and extension.
    always_comb begin
        load_s = mem_wb_memres;
        case (mem_wb_funct3)
            3'b000:  load_s = ext(mem_wb_memres >> {off_s, 3'b000}, 8, 1'b1);
            3'b001:  load_s = ext(mem_wb_memres >> {h_off_s, 3'b000}, 16, 1'b1);
            3'b010:  load_s = ext(mem_wb_memres >> {w_off_s, 3'b000}, 32, 1'b1);
            3'b011:  load_s = mem_wb_memres;
            3'b100:  load_s = ext(mem_wb_memres >> {off_s, 3'b000}, 8, 1'b0);
            3'b101:  load_s = ext(mem_wb_memres >> {h_off_s, 3'b000}, 16, 1'b0);
            3'b110:  load_s = ext(mem_wb_memres >> {w_off_s, 3'b000}, 32, 1'b0);
            default: load_s = mem_wb_memres;
        endcase
    end

    // Writeback result select.
    always_comb begin
        wb_res = mem_wb_alures;
        case (mem_wb_sel)
            2'b00:   wb_res = mem_wb_alures;
            2'b01:   wb_res = load_s;
            2'b10:   wb_res = mem_wb_csr;
            2'b11:   wb_res = mem_wb_pc4;
            default: wb_res = mem_wb_alures;
        endcase
    end

    // History shift register; entry 0 is the newest retired write.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_vld_r[i] <= 1'b0;
                hist_rd_r[i]  <= {RA{1'b0}};
                hist_res_r[i] <= {XLEN{1'b0}};
            end
        end else if (adv_s) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                hist_vld_r[i] <= hist_vld_r[i-1];
                hist_rd_r[i]  <= hist_rd_r[i-1];
                hist_res_r[i] <= hist_res_r[i-1];
            end
            hist_vld_r[0] <= we_noadv_s;
            hist_rd_r[0]  <= mem_wb_rd;
            hist_res_r[0] <= wb_res;
        end
    end

    // Forwarding lookups: scan oldest to newest so the newest match is the last one kept.
    always_comb begin
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = {XLEN{1'b0}};
        q_data2 = {XLEN{1'b0}};
        for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
            q_hit1  = (hist_vld_r[i] && (hist_rd_r[i] == q_rs1) && (q_rs1 != {RA{1'b0}})) ? 1'b1 : q_hit1;
            q_data1 = (hist_vld_r[i] && (hist_rd_r[i] == q_rs1) && (q_rs1 != {RA{1'b0}})) ? hist_res_r[i] : q_data1;
            q_hit2  = (hist_vld_r[i] && (hist_rd_r[i] == q_rs2) && (q_rs2 != {RA{1'b0}})) ? 1'b1 : q_hit2;
            q_data2 = (hist_vld_r[i] && (hist_rd_r[i] == q_rs2) && (q_rs2 != {RA{1'b0}})) ? hist_res_r[i] : q_data2;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_r;

    // Retired-instruction counter; bubbles do not count, non-writing instructions do.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            instret_r <= 64'd0;
        end else if (adv_s && mem_wb_valid) begin
            instret_r <= instret_r + 64'd1;
        end
    end

    assign instret = instret_r;
`else
    assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Randomized self-checking bench for wb_retire_stage against a queue-based reference model.
module tb_wb_retire_stage;
    localparam int XLEN = 32;
    localparam int HD   = 2;
    localparam int RA   = 5;

    logic            clk = 1'b0;
    logic            Rst;
    logic            dbg, mem_hold, mem_wb_valid, mem_wb_regwrite;
    logic [RA-1:0]   mem_wb_rd;
    logic [1:0]      mem_wb_sel;
    logic [2:0]      mem_wb_funct3, mem_wb_addr_lo;
    logic [XLEN-1:0] mem_wb_alures, mem_wb_memres, mem_wb_csr, mem_wb_pc4;
    logic [XLEN-1:0] wb_res;
    logic            wb_we;
    logic [RA-1:0]   wb_rd;
    logic [RA-1:0]   q_rs1, q_rs2;
    logic            q_hit1, q_hit2;
    logic [XLEN-1:0] q_data1, q_data2;
    logic [63:0]     instret;

    wb_retire_stage #(.XLEN(XLEN), .HIST_DEPTH(HD), .RA(RA)) dut (
        .clk(clk), .Rst(Rst), .dbg(dbg), .mem_hold(mem_hold),
        .mem_wb_valid(mem_wb_valid), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_sel(mem_wb_sel), .mem_wb_funct3(mem_wb_funct3),
        .mem_wb_addr_lo(mem_wb_addr_lo), .mem_wb_alures(mem_wb_alures),
        .mem_wb_memres(mem_wb_memres), .mem_wb_csr(mem_wb_csr), .mem_wb_pc4(mem_wb_pc4),
        .wb_res(wb_res), .wb_we(wb_we), .wb_rd(wb_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [4:0]  rd;
        logic [31:0] res;
    } ent_t;

    ent_t        hist[$];
    logic [63:0] m_instret;
    int          checks   = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        hist.delete();
        for (int i = 0; i < HD; i++) hist.push_back('{1'b0, 5'd0, 32'd0});
        m_instret = 64'd0;
    endfunction

    // Reference load: byte/half/word picked at the naturally aligned offset within a 32-bit word.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [2:0] a, input logic [31:0] m);
        int unsigned off, b, h;
        off = a % 4;
        b   = (m >> (8 * off)) & 32'hFF;
        h   = (m >> (8 * ((off / 2) * 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return m;
        endcase
    endfunction

    function automatic logic [31:0] m_res();
        case (mem_wb_sel)
            2'd0:    return mem_wb_alures;
            2'd1:    return m_load(mem_wb_funct3, mem_wb_addr_lo, mem_wb_memres);
            2'd2:    return mem_wb_csr;
            default: return mem_wb_pc4;
        endcase
    endfunction

    function automatic void m_lookup(input logic [4:0] rs, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (rs != 5'd0) begin
            for (int i = 0; i < hist.size(); i++) begin
                if (!hit && hist[i].vld && hist[i].rd == rs) begin
                    hit = 1'b1;
                    d   = hist[i].res;
                end
            end
        end
    endfunction

    // Check all outputs against the model, clock once, then advance the model.
    task automatic cycle(input string tag);
        logic        adv, wen, h;
        logic [31:0] r, d;
        #1;
        adv = !dbg && !mem_hold;
        wen = mem_wb_valid && mem_wb_regwrite && (mem_wb_rd != 5'd0);
        r   = m_res();
        check_eq({tag, ":wb_res"}, wb_res, r);
        check_eq({tag, ":wb_we"}, wb_we, wen && adv && !Rst);
        check_eq({tag, ":wb_rd"}, wb_rd, mem_wb_rd);
        m_lookup(q_rs1, h, d);
        check_eq({tag, ":hit1"}, q_hit1, h);
        check_eq({tag, ":data1"}, q_data1, d);
        m_lookup(q_rs2, h, d);
        check_eq({tag, ":hit2"}, q_hit2, h);
        check_eq({tag, ":data2"}, q_data2, d);
`ifdef WB_INSTRET_EN
        check_eq({tag, ":instret"}, instret, m_instret);
`else
        check_eq({tag, ":instret"}, instret, 64'd0);
`endif
        @(posedge clk);
        if (Rst) begin
            m_reset();
        end else if (adv) begin
            hist.push_front('{wen, mem_wb_rd, r});
            void'(hist.pop_back());
            if (mem_wb_valid) m_instret = m_instret + 64'd1;
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] v);
        mem_wb_valid    = 1'b1;
        mem_wb_regwrite = 1'b1;
        mem_wb_rd       = rd;
        mem_wb_sel      = 2'd0;
        mem_wb_alures   = v;
    endtask

    task automatic bubble();
        mem_wb_valid    = 1'b0;
        mem_wb_regwrite = 1'b0;
    endtask

    logic [2:0] f3_list [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2};

    initial begin
        Rst = 1'b1; dbg = 1'b0; mem_hold = 1'b0;
        mem_wb_funct3 = 3'd0; mem_wb_addr_lo = 3'd0;
        mem_wb_memres = 32'd0; mem_wb_csr = 32'd0; mem_wb_pc4 = 32'd0;
        q_rs1 = 5'd5; q_rs2 = 5'd0;
        m_reset();
        wr(5'd5, 32'h1234);
        @(negedge clk);
        #1;
        check_eq("rst_we", wb_we, 1'b0);
        check_eq("rst_hit1", q_hit1, 1'b0);
        check_eq("rst_instret", instret, 64'd0);
        cycle("rst");
        Rst = 1'b0;

        // Load extraction examples.
        mem_wb_sel = 2'd1; mem_wb_funct3 = 3'd0; mem_wb_addr_lo = 3'd3; mem_wb_memres = 32'h80FF_0000;
        mem_wb_rd = 5'd3;
        #1 check_eq("lb_lit", wb_res, 32'hFFFF_FF80);
        cycle("lb");
        mem_wb_funct3 = 3'd4;
        #1 check_eq("lbu_lit", wb_res, 32'h0000_0080);
        cycle("lbu");

        // Back-to-back writes to x5: newest wins.
        wr(5'd5, 32'h11); cycle("x5a");
        wr(5'd5, 32'h22); cycle("x5b");
        bubble(); q_rs1 = 5'd5;
        #1 check_eq("fwd_hit", q_hit1, 1'b1);
        check_eq("fwd_data", q_data1, 32'h22);
        cycle("x5c");

        // x0 is never written or forwarded.
        wr(5'd0, 32'h99);
        #1 check_eq("x0_we", wb_we, 1'b0);
        cycle("x0a");
        bubble(); q_rs1 = 5'd0;
        #1 check_eq("x0_hit", q_hit1, 1'b0);
        check_eq("x0_data", q_data1, 32'd0);
        cycle("x0b");

        // Memory stall freezes history and suppresses the write.
        wr(5'd6, 32'h33); mem_hold = 1'b1; q_rs1 = 5'd6;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("hold_we", wb_we, 1'b0);
            check_eq("hold_hit", q_hit1, 1'b0);
            cycle("hold");
        end
        mem_hold = 1'b0;
        cycle("release");
        bubble();
        #1 check_eq("rel_hit", q_hit1, 1'b1);
        check_eq("rel_data", q_data1, 32'h33);
        cycle("rel");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            dbg             = ($urandom_range(0, 9) == 0);
            mem_hold        = ($urandom_range(0, 7) == 0);
            mem_wb_valid    = ($urandom_range(0, 3) != 0);
            mem_wb_regwrite = $urandom_range(0, 1);
            mem_wb_rd       = 5'($urandom_range(0, 7));
            mem_wb_sel      = 2'($urandom_range(0, 3));
            mem_wb_funct3   = f3_list[$urandom_range(0, 5)];
            mem_wb_addr_lo  = 3'($urandom_range(0, 7));
            mem_wb_alures   = $urandom;
            mem_wb_memres   = $urandom;
            mem_wb_csr      = $urandom;
            mem_wb_pc4      = $urandom;
            q_rs1           = 5'($urandom_range(0, 7));
            q_rs2           = 5'($urandom_range(0, 7));
            cycle("rnd");
        end
        dbg = 1'b0; mem_hold = 1'b0;

        // Asynchronous reset mid-cycle with a full history.
        wr(5'd7, 32'h77); cycle("fill1");
        wr(5'd8, 32'h88); cycle("fill2");
        wr(5'd9, 32'h99); q_rs1 = 5'd7; q_rs2 = 5'd8;
        #1 check_eq("pre_hit1", q_hit1, 1'b1);
        check_eq("pre_hit2", q_hit2, 1'b1);
        #2 Rst = 1'b1;
        #1 check_eq("arst_hit1", q_hit1, 1'b0);
        check_eq("arst_hit2", q_hit2, 1'b0);
        check_eq("arst_data1", q_data1, 32'd0);
        check_eq("arst_we", wb_we, 1'b0);
        @(posedge clk);
        @(negedge clk);
        m_reset();
        Rst = 1'b0;

        // Five retired instructions and two bubbles.
        for (int i = 0; i < 7; i++) begin
            if (i == 2 || i == 5) bubble();
            else begin
                wr(5'(i + 1), 32'(i));
                mem_wb_regwrite = (i != 3);
            end
            cycle("cnt");
        end
`ifdef WB_INSTRET_EN
        #1 check_eq("instret5", instret, 64'd5);
        dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
        m_instret     = 64'hFFFF_FFFF_FFFF_FFFF;
        wr(5'd1, 32'd1); cycle("wrap");
        #1 check_eq("instret_wrap", instret, 64'd0);
`else
        #1 check_eq("instret_off", instret, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
